// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, single-outstanding imem fetch, 2-entry instruction queue toward decode.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_squashed counters.
module fetch_pc_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] pc_plus4,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [63:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed
`endif
);
    logic [63:0] r_pc, r_out_pc, r_q0_pc, r_q1_pc;
    logic [31:0] r_q0_inst, r_q1_inst;
    logic [1:0]  r_count;
    logic        r_out, r_drop, r_run;
    logic [63:0] w_pc_plus4;
    logic        w_hs, w_rsp, w_push, w_pop, w_out_nxt, w_slot;

    assign w_pc_plus4     = r_pc + 64'd4;
    assign pc_plus4       = w_pc_plus4;
    // r_run keeps the request low during reset and for the cycle of release
    assign imem_req_valid = r_run && !r_out && !r_count[1];
    assign imem_req_addr  = r_pc;
    assign inst_valid     = r_count != 2'd0;
    assign inst_data      = r_q0_inst;
    assign inst_pc        = r_q0_pc;
    assign w_hs           = imem_req_valid && imem_req_ready;
    assign w_rsp          = imem_rsp_valid && r_out;
    assign w_push         = w_rsp && !r_drop && !redirect_valid;
    assign w_pop          = inst_valid && inst_ready;
    assign w_out_nxt      = w_hs ? 1'b1 : (w_rsp ? 1'b0 : r_out);
    assign w_slot         = r_count[1] | (r_count[0] & ~w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc      <= RESET_PC;
            r_out_pc  <= 64'd0;
            r_out     <= 1'b0;
            r_drop    <= 1'b0;
            r_run     <= 1'b0;
            r_count   <= 2'd0;
            r_q0_pc   <= 64'd0;
            r_q1_pc   <= 64'd0;
            r_q0_inst <= 32'd0;
            r_q1_inst <= 32'd0;
        end else begin
            r_run   <= 1'b1;
            r_pc    <= redirect_valid ? {redirect_pc[63:2], 2'b00} : (w_hs ? w_pc_plus4 : r_pc);
            r_out   <= w_out_nxt;
            r_drop  <= redirect_valid ? w_out_nxt : (w_rsp ? 1'b0 : r_drop);
            r_count <= redirect_valid ? 2'd0 : r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_hs)
                r_out_pc <= r_pc;
            if (w_pop && r_count[1]) begin
                r_q0_pc   <= r_q1_pc;
                r_q0_inst <= r_q1_inst;
            end
            if (w_push && !w_slot) begin
                r_q0_pc   <= r_out_pc;
                r_q0_inst <= imem_rsp_data;
            end
            if (w_push && w_slot) begin
                r_q1_pc   <= r_out_pc;
                r_q1_inst <= imem_rsp_data;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic w_squash;
    assign w_squash = w_rsp && (r_drop || redirect_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched  <= 32'd0;
            perf_squashed <= 32'd0;
        end else begin
            perf_fetched  <= perf_fetched + {31'd0, w_push};
            perf_squashed <= perf_squashed + {31'd0, w_squash};
        end
    end
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed and random fetch traffic against a queue-based reference model.
module tb_fetch_pc_unit;
    localparam logic [63:0] RPC = 64'h1000;

    logic        clk = 1'b0, reset_n = 1'b1;
    logic        redirect_valid = 1'b0, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0, inst_ready = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic [63:0] pc_plus4, imem_req_addr, inst_pc;
    logic        imem_req_valid, inst_valid;
    logic [31:0] inst_data;

    fetch_pc_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset_n(reset_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc_plus4(pc_plus4),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(), .perf_squashed()
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_pc, m_opc, a_hold;
    bit          m_out, m_drop, m_run, mem_pend;
    int          mem_cnt, lat, ncmp, nerr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_pc = RPC; m_opc = 64'd0; m_out = 0; m_drop = 0; m_run = 0;
        q.delete();
        mem_pend = 0; mem_cnt = 0;
    endtask

    task automatic chk_reset();
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_inst_data", {32'd0, inst_data}, 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_pc_plus4", pc_plus4, RPC + 64'd4);
    endtask

    // Called just after a falling edge: check outputs, drive one cycle of inputs, advance the model.
    task automatic cyc(input bit rdy, input bit irdy, input bit rv, input logic [63:0] rpc, input bit xr);
        bit   exp_v, hs, rsp, pop;
        ent_t e;
        exp_v = m_run && !m_out && q.size() < 2;
        chk("req_valid", {63'd0, imem_req_valid}, {63'd0, exp_v});
        chk("req_addr", imem_req_addr, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 64'd4);
        chk("inst_valid", {63'd0, inst_valid}, {63'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("inst_pc", inst_pc, q[0].pc);
            chk("inst_data", {32'd0, inst_data}, {32'd0, q[0].inst});
        end
        imem_rsp_data = $urandom;
        if (mem_pend && mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            mem_pend = 0;
        end else begin
            if (mem_pend) mem_cnt--;
            imem_rsp_valid = xr && !mem_pend;
        end
        imem_req_ready = rdy; inst_ready = irdy; redirect_valid = rv; redirect_pc = rpc;
        hs  = exp_v && rdy;
        rsp = imem_rsp_valid && m_out;
        pop = q.size() != 0 && irdy;
        if (hs) begin mem_pend = 1; mem_cnt = lat; end
        if (pop) void'(q.pop_front());
        if (rsp && !m_drop && !rv) begin
            e.pc = m_opc; e.inst = imem_rsp_data;
            q.push_back(e);
        end
        if (rv) q.delete();
        if (hs) m_opc = m_pc;
        m_drop = rv ? (hs || (m_out && !rsp)) : (rsp ? 1'b0 : m_drop);
        m_out  = hs || (m_out && !rsp);
        m_pc   = rv ? {rpc[63:2], 2'b00} : (hs ? m_pc + 64'd4 : m_pc);
        m_run  = 1;
        @(negedge clk);
    endtask

    initial begin
        ncmp = 0; nerr = 0; lat = 0;
        reset_model();
        #1 reset_n = 1'b0;
        #1 chk_reset();
        @(negedge clk);
        reset_n = 1'b1;
        // streaming with zero-wait memory and always-ready decode
        repeat (10) cyc(1, 1, 0, 64'd0, 0);
        // decode stalled: queue fills to two, issue stops, then drains in order
        repeat (10) cyc(1, 0, 0, 64'd0, 0);
        chk("full_req_valid", {63'd0, imem_req_valid}, 64'd0);
        repeat (6) cyc(1, 1, 0, 64'd0, 0);
        // redirect while a slow request is outstanding
        lat = 2;
        for (int i = 0; i < 6 && !m_out; i++) cyc(1, 1, 0, 64'd0, 0);
        cyc(1, 1, 1, 64'h2002, 0);
        chk("redir_addr", imem_req_addr, 64'h2000);
        chk("redir_empty", {63'd0, inst_valid}, 64'd0);
        lat = 0;
        repeat (8) cyc(1, 1, 0, 64'd0, 0);
        // redirect coinciding with a handshake and a stray response
        for (int i = 0; i < 6 && !(!m_out && q.size() < 2); i++) cyc(1, 1, 0, 64'd0, 0);
        cyc(1, 1, 1, 64'h3000, 1);
        repeat (6) cyc(1, 1, 0, 64'd0, 0);
        // memory not ready: request must hold steady
        repeat (4) cyc(0, 1, 0, 64'd0, 0);
        a_hold = imem_req_addr;
        repeat (5) begin
            cyc(0, 1, 0, 64'd0, 0);
            chk("hold_addr", imem_req_addr, a_hold);
            chk("hold_valid", {63'd0, imem_req_valid}, 64'd1);
            chk("hold_plus4", pc_plus4, a_hold + 64'd4);
        end
        // mid-stream reset with queued entries, then a stale response after release
        repeat (8) cyc(1, 0, 0, 64'd0, 0);
        reset_n = 1'b0;
        #1 chk_reset();
        reset_model();
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1, 1, 0, 64'd0, 1);
        chk("post_rst_addr", imem_req_addr, RPC);
        repeat (6) cyc(1, 1, 0, 64'd0, 0);
        // random traffic
        repeat (3000) begin
            lat = $urandom % 3;
            cyc($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 12 == 0,
                {$urandom, $urandom}, $urandom % 8 == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end of the core: holds the 64-bit program counter, issues one instruction-memory request at a time, and buffers returned instructions in a 2-entry queue toward decode. It exports `pc_plus4` to the next-PC 2:1 mux's sequential input and takes that mux's selected target back as `redirect_pc`. Redirects from execute flush the queue and squash any in-flight response.

## Interface
- `RESET_PC`, default 64'h0000_0000_0000_0000, PC value loaded by reset; bits [1:0] must be zero.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `redirect_valid` input 1: taken branch or jump this cycle.
- `redirect_pc` input 64: redirect target; bits [1:0] are ignored and treated as 0.
- `pc_plus4` output 64: current fetch PC + 4, to the next-PC mux.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts the request.
- `imem_req_addr` output 64: fetch address, equal to the current PC.
- `imem_rsp_valid` input 1: one-cycle response pulse.
- `imem_rsp_data` input 32: instruction word.
- `inst_valid` output 1: queue head valid.
- `inst_ready` input 1: decode accepts the head.
- `inst_data` output 32: head instruction.
- `inst_pc` output 64: head instruction's PC.

## Operation
- State:
  - `pc` (64 bits).
  - `outstanding` flag.
  - `out_pc`: PC of the in-flight request.
  - `drop` flag.
  - 2-entry FIFO of {pc, inst} with a 2-bit count.
- Request issue:
  - `imem_req_valid` = !outstanding && count < 2, driven from registered state only; no combinational path from any input.
  - Handshake is `imem_req_valid && imem_req_ready`. On handshake: outstanding <= 1, out_pc <= pc, pc <= pc + 4 (mod 2^64).
  - With no redirect, valid and address stay stable until the handshake.
- Response:
  - When `imem_rsp_valid && outstanding`: outstanding <= 0. If drop is 0, push {out_pc, imem_rsp_data}; if drop is 1, discard the response and clear drop.
  - `imem_rsp_valid` while !outstanding is ignored.
- Pop: `inst_valid && inst_ready` removes the head. Push and pop may occur in the same cycle, leaving count unchanged.
- Redirect (highest priority):
  - pc <= {redirect_pc[63:2], 2'b00}.
  - count <= 0.
  - drop <= 1 if a request is outstanding after this cycle. This includes a request handshaking in the same cycle and excludes one whose response arrives in the same cycle.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle completes as a normal handshake, and the queue is still flushed.
  - Redirect does not pc + 4 increment in the same cycle, even if a request handshakes.
  - A pending unaccepted request changes to the new address in the next cycle. The instruction memory tolerates this.
- Queue full (count 2) blocks issue. Overflow cannot occur because issue requires count < 2 and only one request is ever outstanding.
- `inst_data` and `inst_pc` show the head entry. When empty they hold their last values; reset value is 0.

## Timing
- Reset (asynchronous assert):
  - pc = RESET_PC; outstanding = 0; drop = 0; count = 0.
  - `inst_valid` = 0, `inst_data` = 0, `inst_pc` = 0.
  - `imem_req_valid` = 0 while `reset_n` is low.
  - `pc_plus4` = RESET_PC + 4.
- First edge after reset release: `imem_req_valid` = 1, `imem_req_addr` = RESET_PC.
- Response in cycle N gives `inst_valid` in cycle N+1 (registered queue).
- Response in cycle N gives the next request at earliest in cycle N+1.
- Peak throughput is 1 instruction per 2 cycles with zero-wait memory.
- Redirect in cycle N:
  - `imem_req_addr` = target in N+1.
  - `imem_req_valid` in N+1 only if nothing is outstanding; otherwise it waits for the squashed response.
- Reset mid-operation clears all state immediately. Any response arriving after release is ignored because outstanding = 0.

## Configuration
- `FETCH_PERF_CNT_EN`: when defined, adds two counters and their outputs.
  - `perf_fetched` output 32: increments on each queue push.
  - `perf_squashed` output 32: increments on each discarded response.
  - Both reset to 0 and wrap at 2^32.
- When undefined, the ports and logic are absent and all other behaviour is identical.

## Test plan
- Reset release with RESET_PC = 64'h1000, memory ready and 1-cycle response, inst_ready = 1 -> requests at 1000, 1004, 1008 in alternating cycles; inst_pc sequence 1000, 1004, 1008 with the matching data.
- inst_ready held 0 -> exactly two entries are queued and imem_req_valid stays 0; raising inst_ready drains the queue in order and issue resumes.
- Redirect to 64'h2002 while a request to 1004 is outstanding -> the 1004 response is discarded; the next request goes to 2000; queue empty in the cycle after redirect; perf_squashed = 1 with FETCH_PERF_CNT_EN.
- Redirect in the same cycle as request handshake and response arrival -> the arriving response is discarded, the new request's response is squashed, and the next issued address is the target.
- imem_req_ready held 0 for 5 cycles -> imem_req_valid and imem_req_addr stay stable; pc_plus4 = addr + 4.
- reset_n asserted mid-stream with entries queued -> inst_valid drops asynchronously; after release the first request is to RESET_PC and a late stale response is ignored.
